// File: rtl/riscv_bp_types_pkg.sv
// Shared branch-predictor types and configuration presets.
// Contents:
//   DEFAULT_RSB_ENTRIES, RSB_PTR_W, RSB_CNT_W, RSB_ADDR_W : RSB preset widths
//   rsb_ckpt_t : return-stack checkpoint {tos, count[, top_data]}
// Optional feature macro: RSB_TOP_REPAIR_EN (adds top_data to the checkpoint).
package riscv_bp_types_pkg;

    localparam int unsigned DEFAULT_RSB_ENTRIES = 8;
    localparam int unsigned RSB_PTR_W           = $clog2(DEFAULT_RSB_ENTRIES);
    localparam int unsigned RSB_CNT_W           = $clog2(DEFAULT_RSB_ENTRIES + 1);
    localparam int unsigned RSB_ADDR_W          = 32;

    // Snapshot of the return stack taken with every predicted branch.
    typedef struct packed {
        logic [RSB_PTR_W-1:0]  tos;
        logic [RSB_CNT_W-1:0]  count;
`ifdef RSB_TOP_REPAIR_EN
        logic [RSB_ADDR_W-1:0] top_data;
`endif
    } rsb_ckpt_t;

endpackage

// File: rtl/riscv_return_stack_buffer.sv
// Return stack buffer for the fetch-stage branch predictor.
// Pushes link addresses on predicted calls, supplies the top entry as the
// target of predicted returns, and exports a checkpoint so execute can
// restore the stack after a misprediction.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   push_i, push_addr_i  : predicted call and its link address
//   pop_i                : predicted return
//   pred_valid_o         : stack non-empty
//   pred_target_o        : current top-of-stack entry
//   ckpt_o               : current {tos, count[, top_data]}
//   restore_i, restore_ckpt_i : misprediction recovery
//   flush_i              : empty the stack (pointers only)
// Optional feature macro: RSB_TOP_REPAIR_EN (checkpoint carries the top entry,
// which is written back on restore).
module riscv_return_stack_buffer
    import riscv_bp_types_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_RSB_ENTRIES,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic                  pop_i,
    output logic                  pred_valid_o,
    output logic [ADDR_WIDTH-1:0] pred_target_o,
    output rsb_ckpt_t             ckpt_o,
    input  logic                  restore_i,
    input  rsb_ckpt_t             restore_ckpt_i,
    input  logic                  flush_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Elaboration checks: pointer wrap relies on a power-of-two depth, and the
    // checkpoint layout is fixed by the package preset.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("riscv_return_stack_buffer: DEPTH must be a power of two >= 2");
    end
    if ((PTR_W != RSB_PTR_W) || (CNT_W != RSB_CNT_W)) begin : g_bad_ckpt
        $error("riscv_return_stack_buffer: DEPTH does not match rsb_ckpt_t widths");
    end
`ifdef RSB_TOP_REPAIR_EN
    if (ADDR_WIDTH != RSB_ADDR_W) begin : g_bad_addr
        $error("riscv_return_stack_buffer: ADDR_WIDTH does not match rsb_ckpt_t.top_data");
    end
`endif

    logic [PTR_W-1:0]      r_tos;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0]      w_tos_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_wr_en;
    logic [PTR_W-1:0]      w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_wr_data;
    logic                  w_empty;

    assign w_empty = (r_count == '0);

    // Next-state: flush > restore > push/pop.
    always_comb begin
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_tos;
        w_wr_data   = push_addr_i;

        if (flush_i) begin
            w_tos_nxt   = '0;
            w_count_nxt = '0;
        end else if (restore_i) begin
            w_tos_nxt   = PTR_W'(restore_ckpt_i.tos);
            w_count_nxt = CNT_W'(restore_ckpt_i.count);
`ifdef RSB_TOP_REPAIR_EN
            w_wr_en     = 1'b1;
            w_wr_idx    = PTR_W'(restore_ckpt_i.tos);
            w_wr_data   = ADDR_WIDTH'(restore_ckpt_i.top_data);
`endif
        end else if (push_i && (!pop_i || w_empty)) begin
            // Plain push; on a full stack the oldest slot is overwritten.
            w_tos_nxt   = r_tos + PTR_W'(1);
            w_wr_en     = 1'b1;
            w_wr_idx    = r_tos + PTR_W'(1);
            w_count_nxt = (r_count == CNT_W'(DEPTH)) ? r_count : r_count + CNT_W'(1);
        end else if (push_i && pop_i) begin
            // Return-then-call: replace the top entry in place.
            w_wr_en     = 1'b1;
            w_wr_idx    = r_tos;
        end else if (pop_i && !w_empty) begin
            w_tos_nxt   = r_tos - PTR_W'(1);
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // State registers; storage is cleared on reset but not on flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tos   <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PTR_W'(i)] <= '0;
            end
        end else begin
            r_tos   <= w_tos_nxt;
            r_count <= w_count_nxt;
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= w_wr_data;
            end
        end
    end

    // Zero-latency read path from registered state.
    assign pred_valid_o  = !w_empty;
    assign pred_target_o = r_mem[r_tos];

    always_comb begin
        ckpt_o          = '0;
        ckpt_o.tos      = RSB_PTR_W'(r_tos);
        ckpt_o.count    = RSB_CNT_W'(r_count);
`ifdef RSB_TOP_REPAIR_EN
        ckpt_o.top_data = RSB_ADDR_W'(r_mem[r_tos]);
`endif
    end

endmodule
